mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
- Bus-slave memory controller on a multiplexed 16-bit address/data bus.
- Owns one 4K x 16-bit page of memory, selected when address bits [15:12] equal PAGE.
- Performs fixed 4-word burst reads and writes started by an address phase qualified by AddrValid.
- Sits between the processor bus and local storage; ignores all traffic addressed to other pages.

Parameters:
- PAGE, 4'h2, 4-bit page number; the controller responds only when address bits [15:12] equal PAGE.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- resetH  input  1  reset, asynchronous, active-low.
- AddrData  inout  16  multiplexed bus: address in the address phase, data in the data phases. Tri-stated by the controller except while it returns read data.
- AddrValid  input  1  high for one cycle marks the address phase; AddrData holds the address.
- rw  input  1  direction, sampled with the address: 1 = read, 0 = write.

Behaviour:
- Storage: 4096 x 16 array indexed by addr[11:0]. Contents are not cleared by reset.
- Edge numbering: E0 is the rising edge where AddrValid=1 is sampled in IDLE; E1..E5 are the following rising edges.
- FSM states: IDLE, TURN, WDATA, RDATA. A 2-bit beat counter and a 12-bit latched offset support the FSM.
- IDLE: at an edge with AddrValid=1 and AddrData[15:12]==PAGE, latch offset=AddrData[11:0] and latch rw, then go to TURN.
- IDLE with a non-matching page: stay in IDLE. No write, no drive, no busy tracking.
- TURN: one dead/turnaround cycle (E0 to E1).
  - At E1, go to WDATA (rw=0) or RDATA (rw=1) with beat=0.
  - On the RDATA transition, load the read register with mem[offset] and enable the bus driver.
- WDATA: at E2, E3, E4, E5, write AddrData into mem[offset+beat] for beat 0..3, then increment beat.
  - After the write at E5 (beat 3), return to IDLE.
  - The controller never drives the bus during a write.
- RDATA: word i (mem[offset+i]) is driven from just after edge E(1+i) until edge E(2+i), for i=0..3.
  - The read register and driver enable are flopped. Data is stable before the next rising edge and is valid for a sample taken shortly after the launching edge.
  - At E5, release the bus (high-Z) and return to IDLE.
- Address arithmetic: offset+beat is computed modulo 4096. A burst wraps within the page (0xFFF to 0x000) and never touches another page.
- AddrValid while not in IDLE is ignored. The earliest next accepted address edge is E6.
- Bus drive: AddrData is driven only when state==RDATA and the driver enable is set; otherwise it is 'z. No drive in IDLE, TURN or WDATA, or for a non-matching page.
- Reset (resetH=0, asynchronous): state=IDLE, beat=0, driver enable=0 so the bus goes to Z immediately, and latched offset/rw are cleared.
  - Reset during a burst aborts it. Writes already completed remain in memory; remaining beats are not performed.
- After reset deasserts, the first address phase may be accepted at the next rising edge.

Test Plan:
- Reset: hold resetH=0 for 2 cycles -> AddrData reads 'z; the FSM accepts an address 2 cycles after release.
- Write 0x2000 with ABCD,1234,5678,9ABC (data on E2..E5), then read 0x2000 -> bus returns ABCD,1234,5678,9ABC on beats after E1..E4; bus is 'z before E1 and after E5.
- Foreign page: write 0x5000 with ABCD,1234,5678,9ABC, then read 0x5000 -> AddrData stays 'z for the whole read (all four samples differ from the written data).
  - A subsequent read of 0x2000 is still unchanged.
- Wrap: write 0x2FFE with 1111,2222,3333,4444 -> reading 0x2FFE returns 1111,2222 and reading 0x2000 returns 3333,4444.
- Reset mid-read: start read of 0x2000 and assert resetH=0 after E2 -> bus goes 'z asynchronously and the FSM is in IDLE; a new read after release returns the correct data.
- AddrValid pulsed at E3 during a burst to 0x2010 -> ignored; the burst completes normally and a read at E6+ works.

Source files
------------

// File: rtl/mem_controller.sv
// Bus-slave memory controller: owns one 4K x 16 page on a multiplexed address/data bus and
// services fixed 4-word burst reads and writes addressed to that page.
module mem_controller #(
    parameter logic [3:0] PAGE = 4'h2
) (
    input  logic        clk,
    input  logic        resetH,
    inout  wire  [15:0] AddrData,
    input  logic        AddrValid,
    input  logic        rw
);

    typedef enum logic [1:0] {
        StIdle,
        StTurn,
        StWdata,
        StRdata
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [11:0] offset_q, offset_d;
    logic        rw_q, rw_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        drv_en_q, drv_en_d;

    logic        wr_en;
    logic [11:0] mem_addr;
    logic [15:0] mem [4096];

    // 12-bit sum keeps every burst inside the page (0xFFF wraps to 0x000).
    assign mem_addr = offset_q + {10'd0, beat_q};

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        offset_d  = offset_q;
        rw_d      = rw_q;
        rd_data_d = rd_data_q;
        drv_en_d  = drv_en_q;
        wr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (AddrValid && (AddrData[15:12] == PAGE)) begin
                    offset_d = AddrData[11:0];
                    rw_d     = rw;
                    state_d  = StTurn;
                end
            end
            StTurn: begin
                beat_d = 2'd0;
                if (rw_q) begin
                    rd_data_d = mem[offset_q];
                    drv_en_d  = 1'b1;
                    state_d   = StRdata;
                end else begin
                    state_d = StWdata;
                end
            end
            StWdata: begin
                wr_en  = 1'b1;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = StIdle;
                end
            end
            StRdata: begin
                if (beat_q == 2'd3) begin
                    drv_en_d = 1'b0;
                    beat_d   = 2'd0;
                    state_d  = StIdle;
                end else begin
                    // Prefetch the next word so it launches on this edge.
                    rd_data_d = mem[mem_addr + 12'd1];
                    beat_d    = beat_q + 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetH) begin
        if (!resetH) begin
            state_q   <= StIdle;
            beat_q    <= 2'd0;
            offset_q  <= 12'd0;
            rw_q      <= 1'b0;
            rd_data_q <= 16'd0;
            drv_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            offset_q  <= offset_d;
            rw_q      <= rw_d;
            rd_data_q <= rd_data_d;
            drv_en_q  <= drv_en_d;
        end
    end

    // Storage survives reset; writes stop as soon as reset forces the FSM to idle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[mem_addr] <= AddrData;
        end
    end

    assign AddrData = (state_q == StRdata && drv_en_q) ? rd_data_q : 16'bz;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: stimulus pushes expected bus samples per cycle, a
// monitor pops and compares them; a flat array models the page contents.
module tb_mem_controller;

    logic        clk = 1'b0;
    logic        resetH = 1'b0;
    logic        AddrValid = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] tb_drv = 16'd0;
    logic        tb_oe = 1'b0;

    // Weak pull-up makes a released bus read as all ones in any simulator.
    tri1 [15:0] AddrData;
    assign AddrData = tb_oe ? tb_drv : 16'bz;

    localparam logic [15:0] Released = 16'hFFFF;

    mem_controller #(.PAGE(4'h2)) dut (
        .clk(clk),
        .resetH(resetH),
        .AddrData(AddrData),
        .AddrValid(AddrValid),
        .rw(rw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model [4096];
    bit          known [4096];

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endfunction

    function automatic void expect_at(input int c, input logic [15:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endfunction

    // Monitor: sample 2 time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: slot %0d missed, now %0d", e.name, e.cyc, cyc);
                end else begin
                    check(e.name, AddrData, e.val);
                end
            end
        end
    end

    function automatic logic [15:0] rnd_word();
        return 16'($urandom_range(0, 16'hFFFE));
    endfunction

    // One full burst transaction E0..E5; pulse_at (1..5) raises AddrValid at that edge.
    task automatic burst(input logic [15:0] addr, input logic rd, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
                         input int pulse_at, input string tag);
        logic [15:0] d[4];
        logic        hit;
        int          off;
        int          e0;
        int          a;
        d   = '{d0, d1, d2, d3};
        hit = (addr[15:12] == 4'h2);
        off = int'(addr[11:0]);
        @(negedge clk);
        e0 = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            if (hit && rd && k >= 1 && k <= 4) begin
                a = (off + k - 1) % 4096;
                if (known[a]) expect_at(e0 + k, model[a], $sformatf("%s_w%0d", tag, k - 1));
            end else begin
                expect_at(e0 + k, Released, $sformatf("%s_z%0d", tag, k));
            end
        end
        if (hit && !rd) begin
            for (int i = 0; i < 4; i++) begin
                model[(off + i) % 4096] = d[i];
                known[(off + i) % 4096] = 1'b1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            AddrValid = (k == 0) || (k == pulse_at);
            if (k == 0) begin
                tb_drv = addr;
                tb_oe  = 1'b1;
                rw     = rd;
            end else if (!rd && k >= 2) begin
                tb_drv = d[k-2];
                tb_oe  = 1'b1;
            end else begin
                tb_oe = 1'b0;
            end
            if (k == pulse_at) rw = 1'b1;
            @(posedge clk);
            #1;
            AddrValid = 1'b0;
            tb_oe     = 1'b0;
        end
    endtask

    task automatic reset_mid_read(input logic [15:0] addr);
        int e0;
        int off;
        off = int'(addr[11:0]);
        @(negedge clk);
        e0 = cyc + 1;
        expect_at(e0, Released, "rstrd_z0");
        if (known[off]) expect_at(e0 + 1, model[off], "rstrd_w0");
        if (known[(off + 1) % 4096]) expect_at(e0 + 2, model[(off + 1) % 4096], "rstrd_w1");
        AddrValid = 1'b1;
        tb_drv    = addr;
        tb_oe     = 1'b1;
        rw        = 1'b1;
        @(posedge clk);
        #1;
        AddrValid = 1'b0;
        tb_oe     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        resetH = 1'b0;
        #1;
        check("rst_mid_release", AddrData, Released);
        @(negedge clk);
        check("rst_mid_held", AddrData, Released);
        @(negedge clk);
        resetH = 1'b1;
    endtask

    initial begin
        logic [15:0] addr;
        logic [15:0] w[4];
        logic        rd;
        int          ok;

        for (int i = 0; i < 4096; i++) known[i] = 1'b0;

        resetH = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_bus", AddrData, Released);
        resetH = 1'b1;
        @(posedge clk);

        burst(16'h2000, 1'b0, 16'hABCD, 16'h1234, 16'h5678, 16'h9ABC, -1, "wr0");
        burst(16'h2000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, -1, "rd0");
        burst(16'h5000, 1'b0, 16'hABCD, 16'h1234, 16'h5678, 16'h9ABC, -1, "wrfor");
        burst(16'h5000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, -1, "rdfor");
        burst(16'h2000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, -1, "rd0b");
        burst(16'h2FFE, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, -1, "wrwrap");
        burst(16'h2FFE, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, -1, "rdwraphi");
        burst(16'h2000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, -1, "rdwraplo");
        reset_mid_read(16'h2000);
        burst(16'h2000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, -1, "rdafterrst");
        burst(16'h2010, 1'b0, 16'h2A11, 16'h2ABC, 16'h2C33, 16'h2D44, 3, "wrpulse");
        burst(16'h2010, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 3, "rdpulse");
        burst(16'h2010, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, -1, "rde6");

        for (int n = 0; n < 40; n++) begin
            addr[15:12] = ($urandom_range(0, 4) == 0) ? 4'h5 : 4'h2;
            addr[11:0]  = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3))
                                                      : 12'($urandom_range(0, 32));
            rd = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) w[i] = rnd_word();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            burst(addr, rd, w[0], w[1], w[2], w[3], -1, $sformatf("rnd%0d", n));
        end

        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected samples left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
